// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU_16 op encodings, datapath width and issue FSM states
package alu_pkg;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_FLIP = 3'b101,
        OP_LSR  = 3'b110,
        OP_LSL  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } issue_state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x DATA_W register file, r0 reads zero
//   ra1/rd1, ra2/rd2 : combinational operand read ports
//   dbg_addr/dbg_data: combinational debug read port
//   we_a/wa_a/wd_a   : ALU writeback port (wins on same-address collision)
//   we_b/wa_b/wd_b   : host write port
module alu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we_a,
    input  logic [AW-1:0]     wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [AW-1:0]     wa_b,
    input  logic [DATA_W-1:0] wd_b
);
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (we_b && wa_b != '0) regs[wa_b] <= wd_b;
            // issued later so the ALU writeback overrides a same-address host write
            if (we_a && wa_a != '0) regs[wa_a] <= wd_a;
        end
    end

    assign rd1      = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2      = (ra2 == '0) ? '0 : regs[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback sequencer in front of the registered ALU_16
//   in_*    : instruction handshake (op, rd, rs1, rs2)
//   alu_*   : operands/select to ALU_16, alu_out is its registered result
//   resp_*  : result handshake (data, destination)
//   wr_*    : host register write, blocks instruction acceptance that cycle
//   dbg_*   : combinational register debug read
//   ALU_ISSUE_IMM_EN adds in_imm_sel/in_imm to replace rs2 with an immediate
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
`ifdef ALU_ISSUE_IMM_EN
    input  logic              in_imm_sel,
    input  logic [DATA_W-1:0] in_imm,
`endif
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [AW-1:0]     resp_rd,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    issue_state_t      state_q, state_d;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] rd1, rd2, opnd2;
    logic              accept, wb_en;

    assign in_ready   = (state_q == IDLE) && !wr_en;
    assign accept     = in_valid && in_ready;
    assign resp_valid = (state_q == WB);
    assign resp_data  = resp_valid ? alu_out : '0;
    assign resp_rd    = rd_q;
    assign wb_en      = resp_valid && resp_ready;

`ifdef ALU_ISSUE_IMM_EN
    assign opnd2 = in_imm_sel ? in_imm : rd2;
`else
    assign opnd2 = rd2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && accept) state_d = EXEC;
        if (state_q == EXEC)           state_d = WB;
        if (state_q == WB && wb_en)    state_d = IDLE;
    end

    // ALU inputs only change on accept so they stay stable through EXEC and WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1 <= '0;
            alu_in2 <= '0;
            alu_sel <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            alu_in1 <= rd1;
            alu_in2 <= opnd2;
            alu_sel <= in_op;
            rd_q    <= in_rd;
        end
    end

    alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (in_rs1),
        .rd1      (rd1),
        .ra2      (in_rs2),
        .rd2      (rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we_a     (wb_en),
        .wa_a     (rd_q),
        .wd_a     (alu_out),
        .we_b     (wr_en),
        .wa_b     (wr_addr),
        .wd_b     (wr_data)
    );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench with a behavioural ALU_16
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [2:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
`ifdef ALU_ISSUE_IMM_EN
    logic        in_imm_sel = 1'b0;
    logic [15:0] in_imm = '0;
`endif
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_sel;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic [2:0]  resp_rd;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // ALU_16 stand-in: one-cycle registered result
    always @(posedge clk) begin
        case (alu_sel)
            3'd0: alu_out <= alu_in1 + alu_in2;
            3'd1: alu_out <= alu_in1 - alu_in2;
            3'd2: alu_out <= alu_in1 & alu_in2;
            3'd3: alu_out <= alu_in1 | alu_in2;
            3'd4: alu_out <= alu_in1 ^ alu_in2;
            3'd5: alu_out <= alu_in1 ^ (16'h0001 << alu_in2[3:0]);
            3'd6: alu_out <= alu_in1 >> alu_in2[3:0];
            default: alu_out <= alu_in1 << alu_in2[3:0];
        endcase
    end

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
`ifdef ALU_ISSUE_IMM_EN
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
`endif
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // lat counts edges from the start of the accept cycle to resp_valid; -1 on timeout
    task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input bit ack, output logic [15:0] data,
                          output logic [2:0] rd_o, output int lat);
        int n;
        in_op = op;
        in_rd = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        if (!resp_valid) lat = -1;
        data = resp_data;
        rd_o = resp_rd;
        if (ack && resp_valid) begin
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic [2:0]  r;
        int lat;
        host_write(3'd1, 16'h0055);
        run_op(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, d, r, lat);
        checks++;
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_wb resp_valid got %b want 1", resp_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_async resp_valid got %b want 0", resp_valid); end
        checks++;
        if (resp_data !== 16'h0) begin errors++; $display("FAIL reset_resp_data got %h want 0000", resp_data); end
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), d);
            checks++;
            if (d !== 16'h0) begin errors++; $display("FAIL reset_reg r%0d got %h want 0000", i, d); end
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        wr_en = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_wr_en_in_ready got %b want 0", in_ready); end
        wr_en = 1'b0;
    endtask

    task automatic test_add();
        logic [15:0] d;
        logic [2:0]  r;
        int lat;
        host_write(3'd1, 16'h0005);
        host_write(3'd2, 16'h0003);
        run_op(3'd0, 3'd3, 3'd1, 3'd2, 1'b1, d, r, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
        checks++;
        if (d !== 16'h0008) begin errors++; $display("FAIL add_data got %h want 0008", d); end
        checks++;
        if (r !== 3'd3) begin errors++; $display("FAIL add_rd got %0d want 3", r); end
        read_reg(3'd3, d);
        checks++;
        if (d !== 16'h0008) begin errors++; $display("FAIL add_wb r3 got %h want 0008", d); end
        checks++;
        if (resp_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_return_idle got rv=%b rdy=%b want 0 1", resp_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [2:0]  r;
        int lat;
        run_op(3'd1, 3'd4, 3'd3, 3'd2, 1'b1, d, r, lat);
        checks++;
        if (d !== 16'h0005) begin errors++; $display("FAIL sub_dep got %h want 0005", d); end
        run_op(3'd7, 3'd5, 3'd4, 3'd2, 1'b1, d, r, lat);
        checks++;
        if (d !== 16'h0028) begin errors++; $display("FAIL lsl_dep got %h want 0028", d); end
        read_reg(3'd5, d);
        checks++;
        if (d !== 16'h0028) begin errors++; $display("FAIL lsl_wb r5 got %h want 0028", d); end
        run_op(3'd5, 3'd6, 3'd1, 3'd2, 1'b1, d, r, lat);
        checks++;
        if (d !== 16'h000D) begin errors++; $display("FAIL flip got %h want 000d", d); end
        run_op(3'd1, 3'd7, 3'd2, 3'd1, 1'b1, d, r, lat);
        checks++;
        if (d !== 16'hFFFE) begin errors++; $display("FAIL sub_wrap got %h want fffe", d); end
        run_op(3'd6, 3'd7, 3'd5, 3'd2, 1'b1, d, r, lat);
        checks++;
        if (d !== 16'h0005) begin errors++; $display("FAIL lsr got %h want 0005", d); end
        run_op(3'd2, 3'd7, 3'd6, 3'd5, 1'b1, d, r, lat);
        checks++;
        if (d !== 16'h0008) begin errors++; $display("FAIL and got %h want 0008", d); end
    endtask

    task automatic test_backpressure();
        logic [15:0] d, v;
        logic [2:0]  r;
        int lat;
        run_op(3'd3, 3'd6, 3'd1, 3'd5, 1'b0, d, r, lat);
        checks++;
        if (d !== 16'h002D) begin errors++; $display("FAIL bp_data got %h want 002d", d); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 16'h002D || resp_rd !== 3'd6) begin
                errors++; $display("FAIL bp_hold cyc%0d got rv=%b d=%h rd=%0d want 1 002d 6", i, resp_valid, resp_data, resp_rd);
            end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready); end
            read_reg(3'd6, v);
            checks++;
            if (v !== 16'h000D) begin errors++; $display("FAIL bp_early_wb r6 got %h want 000d", v); end
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", resp_valid); end
        read_reg(3'd6, v);
        checks++;
        if (v !== 16'h002D) begin errors++; $display("FAIL bp_wb r6 got %h want 002d", v); end
    endtask

    task automatic test_r0();
        logic [15:0] d;
        logic [2:0]  r;
        int lat;
        run_op(3'd0, 3'd0, 3'd1, 3'd2, 1'b1, d, r, lat);
        checks++;
        if (d !== 16'h0008 || r !== 3'd0) begin errors++; $display("FAIL r0_resp got d=%h rd=%0d want 0008 0", d, r); end
        host_write(3'd0, 16'hAAAA);
        read_reg(3'd0, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL r0_read got %h want 0000", d); end
        run_op(3'd0, 3'd7, 3'd0, 3'd2, 1'b1, d, r, lat);
        checks++;
        if (d !== 16'h0003) begin errors++; $display("FAIL r0_operand got %h want 0003", d); end
    endtask

    task automatic test_wr_block();
        logic [15:0] d;
        in_op = 3'd0;
        in_rd = 3'd7;
        in_rs1 = 3'd1;
        in_rs2 = 3'd2;
        in_valid = 1'b1;
        wr_en = 1'b1;
        wr_addr = 3'd7;
        wr_data = 16'h1234;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL wrblk_in_ready got %b want 0", in_ready); end
        tick();
        in_valid = 1'b0;
        wr_en = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL wrblk_still_idle got %b want 1", in_ready); end
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL wrblk_no_issue got %b want 0", resp_valid); end
        read_reg(3'd7, d);
        checks++;
        if (d !== 16'h1234) begin errors++; $display("FAIL wrblk_hostwr r7 got %h want 1234", d); end
    endtask

    task automatic test_collision();
        logic [15:0] d;
        logic [2:0]  r;
        int lat;
        run_op(3'd4, 3'd3, 3'd1, 3'd2, 1'b0, d, r, lat);
        checks++;
        if (d !== 16'h0006) begin errors++; $display("FAIL coll_data got %h want 0006", d); end
        wr_en = 1'b1;
        wr_addr = 3'd3;
        wr_data = 16'hBEEF;
        resp_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        resp_ready = 1'b0;
        read_reg(3'd3, d);
        checks++;
        if (d !== 16'h0006) begin errors++; $display("FAIL coll_priority r3 got %h want 0006", d); end
    endtask

`ifdef ALU_ISSUE_IMM_EN
    task automatic test_imm();
        logic [15:0] d;
        logic [2:0]  r;
        int lat;
        in_imm_sel = 1'b1;
        in_imm = 16'h00F0;
        run_op(3'd0, 3'd7, 3'd1, 3'd2, 1'b1, d, r, lat);
        in_imm_sel = 1'b0;
        checks++;
        if (d !== 16'h00F5) begin errors++; $display("FAIL imm_add got %h want 00f5", d); end
    endtask
`endif

    initial begin
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_r0();
        test_wr_block();
        test_collision();
`ifdef ALU_ISSUE_IMM_EN
        test_imm();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
